// File: rtl/char_fifo_if.sv
// Purpose : bundles the generator-side and reader-side signals of char_fifo.
// Latency : none, this file holds only wiring.
// Backpressure: n_cs paces the generator; n_rd pulls bytes out; n_ef/level report occupancy.
//
// Signals (fifo view = slave modport):
//   din   in   8     byte from the character generator
//   n_wr  in   1     generator write strobe, active low
//   n_cs  out  1     grant to generator, active low (low = generator may advance)
//   dout  out  8     registered read data
//   n_rd  in   1     read request, active low
//   n_ef  out  1     empty flag, active low (low = empty)
//   level out  AW+1  number of stored bytes
interface char_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  din;
    logic        n_wr;
    logic        n_cs;
    logic [7:0]  dout;
    logic        n_rd;
    logic        n_ef;
    logic [AW:0] level;

    // Driven by the generator / reader side.
    modport master (
        output din, n_wr, n_rd,
        input  n_cs, dout, n_ef, level
    );

    // Seen by the buffer itself.
    modport slave (
        input  din, n_wr, n_rd,
        output n_cs, dout, n_ef, level
    );
endinterface

// File: rtl/char_fifo.sv
// Purpose : byte buffer behind the character generator; grants each advance, stores fresh bytes in order.
// Latency : grant in cycle t -> byte stored at edge t+2; read sampled at edge e -> dout valid after e.
// Backpressure: n_cs rises combinationally when stored + in-flight bytes reach DEPTH; empty reads are ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   bus        char_fifo_if.slave (din, n_wr, n_cs, dout, n_rd, n_ef, level)
//   underflow  out  sticky read-while-empty flag, present only with CHAR_FIFO_UNDERFLOW_EN defined
//
// Optional feature macro: CHAR_FIFO_UNDERFLOW_EN
// DEPTH must be a power of two (minimum 4) and AW must equal log2(DEPTH).
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       n_rst,
`ifdef CHAR_FIFO_UNDERFLOW_EN
    output logic       underflow,
`endif
    char_fifo_if.slave bus
);

    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          grant_q,  grant_d;
    logic [7:0]    dout_q,   dout_d;
    logic          wr_en;
    logic          rd_en;
    logic [AW+1:0] committed;
    logic          n_cs;

    // A granted advance lands in din one cycle later, so an outstanding grant
    // already owns a slot. Counting it keeps the array from ever overflowing.
    assign committed = {1'b0, count_q} + {{(AW+1){1'b0}}, grant_q};
    assign n_cs      = ~(committed < DEPTH_C);

    // The generator keeps n_wr low forever; only the cycle after a grant
    // carries a new byte, every other strobed cycle is a stale repeat.
    assign wr_en = grant_q & ~bus.n_wr;
    // An empty read is dropped, including when a write lands on the same edge.
    assign rd_en = ~bus.n_rd & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        grant_d  = ~n_cs;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            grant_q  <= 1'b0;
            dout_q   <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            grant_q  <= grant_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

`ifdef CHAR_FIFO_UNDERFLOW_EN
    logic underflow_q, underflow_d;

    assign underflow_d = underflow_q | (~bus.n_rd & (count_q == '0));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;
`endif

    assign bus.n_cs  = n_cs;
    assign bus.dout  = dout_q;
    assign bus.n_ef  = (count_q != '0);
    assign bus.level = count_q;

endmodule

// File: tb/tb_char_fifo.sv
// Purpose : self-checking bench for char_fifo with a behavioural generator and a queue reference model.
// Latency : checks every cycle, outputs sampled 1 time unit after the rising edge.
// Backpressure: the generator advances only on cycles where the buffer's n_cs is low.
module tb_char_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;

    always #5 clk = ~clk;

    char_fifo_if #(.AW(AW)) bus ();

`ifdef CHAR_FIFO_UNDERFLOW_EN
    logic underflow;
`endif

    char_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
`ifdef CHAR_FIFO_UNDERFLOW_EN
        .underflow (underflow),
`endif
        .bus       (bus)
    );

    // Reference model: stored bytes as a queue, plus the outstanding grant.
    logic [7:0] q[$];
    logic       m_grant;
    logic [7:0] m_dout;
    logic       m_und;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gen_next(input logic [7:0] c);
        return (c == 8'h7a) ? 8'h61 : c + 8'd1;
    endfunction

    // Grant rule: low while stored bytes plus an in-flight byte leave room.
    function automatic logic exp_ncs();
        return !((q.size() + int'(m_grant)) < DEPTH);
    endfunction

    task automatic check_outputs();
        chk("level", bus.level, q.size());
        chk("n_ef", bus.n_ef, (q.size() != 0));
        chk("dout", bus.dout, m_dout);
`ifdef CHAR_FIFO_UNDERFLOW_EN
        chk("underflow", underflow, m_und);
`endif
    endtask

    // One clock cycle, entered and left at a falling edge with inputs set.
    task automatic step();
        logic gnt_now;
        logic wr;
        logic rd;
        gnt_now = (bus.n_cs == 1'b0);
        chk("n_cs", bus.n_cs, exp_ncs());
        wr = m_grant && (bus.n_wr == 1'b0);
        rd = (bus.n_rd == 1'b0) && (q.size() != 0);
        if (bus.n_rd == 1'b0 && q.size() == 0) m_und = 1'b1;
        m_grant = !exp_ncs();
        if (rd) m_dout = q.pop_front();
        if (wr) q.push_back(bus.din);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        // Generator advances one step after each edge at which it was granted.
        if (gnt_now) bus.din = gen_next(bus.din);
    endtask

    task automatic do_reset();
        n_rst   = 1'b0;
        bus.din = 8'h61;
        q.delete();
        m_grant = 1'b0;
        m_dout  = 8'h00;
        m_und   = 1'b0;
        #1;
        chk("rst_n_cs", bus.n_cs, 0);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_n_ef", bus.n_ef, 0);
        chk("rst_level", bus.level, 0);
`ifdef CHAR_FIFO_UNDERFLOW_EN
        chk("rst_underflow", underflow, 0);
`endif
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic wait_level(input int target);
        int n;
        n = 0;
        while (int'(bus.level) != target && n < 100) begin
            step();
            n++;
        end
        chk("wait_level", bus.level, target);
    endtask

    logic [7:0] last_seen;
    logic [7:0] exp_next;
    logic [7:0] held;

    initial begin
        bus.din  = 8'h61;
        bus.n_wr = 1'b0;
        bus.n_rd = 1'b1;
        #1;
        do_reset();

        // Fill with no reads: stops at DEPTH with the grant withdrawn.
        repeat (30) step();
        chk("fill_level", bus.level, 16);
        chk("fill_ncs", bus.n_cs, 1);

        // Generator stalled by the withdrawn grant while n_wr stays low.
        repeat (10) step();
        chk("stall_level", bus.level, 16);

        // Drain: first 16 reads are "b".."q".
        bus.n_rd = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain_order", bus.dout, 32'h62 + i);
        end

        // Continuous reading: every new dout value is the next letter, wrapping z->a.
        last_seen = 8'h71;
        exp_next  = 8'h72;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.dout !== last_seen) begin
                chk("stream", bus.dout, exp_next);
                exp_next  = gen_next(exp_next);
                last_seen = bus.dout;
            end
        end

        // Strobe high: granted bytes are dropped, buffer drains, then empty reads.
        bus.n_wr = 1'b1;
        repeat (25) step();
        chk("empty_level", bus.level, 0);
        chk("empty_n_ef", bus.n_ef, 0);
        held = m_dout;
        repeat (3) step();
        chk("empty_dout_held", bus.dout, held);
`ifdef CHAR_FIFO_UNDERFLOW_EN
        chk("underflow_set", underflow, 1);
`endif
        bus.n_wr = 1'b0;
        bus.n_rd = 1'b1;

        // Random reads and occasional strobe drop-outs against the model.
        repeat (300) begin
            bus.n_rd = 1'($urandom_range(0, 1));
            bus.n_wr = ($urandom_range(0, 7) == 0);
            step();
        end
        bus.n_wr = 1'b0;
        bus.n_rd = 1'b1;

        // Simultaneous write and read at level 5.
        do_reset();
        wait_level(5);
        bus.n_rd = 1'b0;
        step();
        chk("simul_level", bus.level, 5);
        chk("simul_dout", bus.dout, 8'h62);
        repeat (7) step();
        chk("simul_level_hold", bus.level, 5);
        chk("simul_dout_seq", bus.dout, 8'h69);
        bus.n_rd = 1'b1;

        // Reset pulse at level 9, then refill restarts from "b".
        do_reset();
        wait_level(9);
        do_reset();
        repeat (20) step();
        bus.n_rd = 1'b0;
        step();
        chk("refill_first", bus.dout, 8'h62);
        bus.n_rd = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
